// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read-channel arbiter: one outstanding burst, round-robin grant,
// per-requester ARID tagging and sticky RID / RLAST-position error flags.
module axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int S0_ID      = 0,
  parameter int S1_ID      = 1
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_reset_n,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic [ID_WIDTH-1:0]   m_rid,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  err_id,
  output logic                  err_len
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        r_state;
  logic          r_grant;
  logic          r_lastGrant;
  logic [7:0]    r_lenQ;
  logic [7:0]    r_beatCnt;
  logic          r_errId;
  logic          r_errLen;

  logic                w_inAddr;
  logic                w_inData;
  logic                w_winner;
  logic                w_gArvalid;
  logic                w_gRready;
  logic [7:0]          w_gArlen;
  logic [ID_WIDTH-1:0] w_grantId;
  logic                w_sel0;
  logic                w_sel1;
  logic                w_arHs;
  logic                w_rHs;

  assign w_inAddr   = (r_state == ADDR);
  assign w_inData   = (r_state == DATA);
  // On a tie the requester that did not win last time takes the grant.
  assign w_winner   = (s0_arvalid & s1_arvalid) ? ~r_lastGrant : s1_arvalid;
  assign w_gArvalid = r_grant ? s1_arvalid : s0_arvalid;
  assign w_gRready  = r_grant ? s1_rready  : s0_rready;
  assign w_gArlen   = r_grant ? s1_arlen   : s0_arlen;
  assign w_grantId  = r_grant ? ID_WIDTH'(S1_ID) : ID_WIDTH'(S0_ID);
  assign w_sel0     = w_inData & ~r_grant;
  assign w_sel1     = w_inData &  r_grant;

  assign m_arvalid  = w_inAddr & w_gArvalid;
  assign m_araddr   = w_inAddr ? (r_grant ? s1_araddr  : s0_araddr)  : '0;
  assign m_arlen    = w_inAddr ? w_gArlen : '0;
  assign m_arsize   = w_inAddr ? (r_grant ? s1_arsize  : s0_arsize)  : '0;
  assign m_arburst  = w_inAddr ? (r_grant ? s1_arburst : s0_arburst) : '0;
  assign m_arid     = w_inAddr ? w_grantId : '0;
  assign s0_arready = w_inAddr & ~r_grant & m_arready;
  assign s1_arready = w_inAddr &  r_grant & m_arready;

  assign m_rready   = w_inData & w_gRready;
  assign s0_rvalid  = w_sel0 & m_rvalid;
  assign s1_rvalid  = w_sel1 & m_rvalid;
  assign s0_rdata   = w_sel0 ? m_rdata : '0;
  assign s1_rdata   = w_sel1 ? m_rdata : '0;
  assign s0_rresp   = w_sel0 ? m_rresp : '0;
  assign s1_rresp   = w_sel1 ? m_rresp : '0;
  assign s0_rlast   = w_sel0 & m_rlast;
  assign s1_rlast   = w_sel1 & m_rlast;

  assign w_arHs     = m_arvalid & m_arready;
  assign w_rHs      = m_rvalid & m_rready;
  assign err_id     = r_errId;
  assign err_len    = r_errLen;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_reset_n) begin
      r_state     <= IDLE;
      r_grant     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_lenQ      <= 8'd0;
      r_beatCnt   <= 8'd0;
      r_errId     <= 1'b0;
      r_errLen    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s0_arvalid | s1_arvalid) begin
            r_grant     <= w_winner;
            r_lastGrant <= w_winner;
            r_state     <= ADDR;
          end
        end
        ADDR: begin
          if (w_arHs) begin
            r_lenQ    <= w_gArlen;
            r_beatCnt <= 8'd0;
            r_state   <= DATA;
          end else if (!w_gArvalid) begin
            r_state <= IDLE;
          end
        end
        DATA: begin
          if (w_rHs) begin
            r_beatCnt <= r_beatCnt + 8'd1;
            if (m_rid != w_grantId) r_errId <= 1'b1;
            // A burst that ends early, or runs past its length without RLAST, is a length error.
            if (m_rlast) begin
              if (r_beatCnt != r_lenQ) r_errLen <= 1'b1;
              r_state <= IDLE;
            end else if (r_beatCnt == r_lenQ) begin
              r_errLen <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios then randomized bursts,
// judged against a transaction-level round-robin and burst-length model.
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 6;

  logic          cpu_clk = 1'b0;
  logic          cpu_reset_n = 1'b0;
  logic [AW-1:0] s0_araddr = '0, s1_araddr = '0;
  logic [7:0]    s0_arlen = '0, s1_arlen = '0;
  logic [2:0]    s0_arsize = '0, s1_arsize = '0;
  logic [1:0]    s0_arburst = '0, s1_arburst = '0;
  logic          s0_arvalid = 1'b0, s1_arvalid = 1'b0;
  logic          s0_arready, s1_arready;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [1:0]    s0_rresp, s1_rresp;
  logic          s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
  logic          s0_rready = 1'b0, s1_rready = 1'b0;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic [IW-1:0] m_arid;
  logic          m_arvalid;
  logic          m_arready = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    m_rresp = '0;
  logic          m_rlast = 1'b0;
  logic [IW-1:0] m_rid = '0;
  logic          m_rvalid = 1'b0;
  logic          m_rready;
  logic          err_id, err_len;

  int checks = 0;
  int failures = 0;
  int lastWin = 1;
  bit expErrId = 1'b0;
  bit expErrLen = 1'b0;
  logic [AW-1:0] reqAddr [2];
  logic [7:0]    reqLen [2];
  logic [2:0]    reqSize [2];
  logic [1:0]    reqBurst [2];

  axi_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .S0_ID(0), .S1_ID(1)) dut (
    .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .err_id(err_id), .err_len(err_len)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the run completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int who, input bit valid, input int len);
    if (valid) begin
      reqAddr[who]  = $urandom;
      reqLen[who]   = 8'(len);
      reqSize[who]  = 3'($urandom_range(0, 7));
      reqBurst[who] = 2'($urandom_range(0, 3));
    end
    if (who == 0) begin
      s0_arvalid = valid; s0_araddr = reqAddr[0]; s0_arlen = reqLen[0];
      s0_arsize = reqSize[0]; s0_arburst = reqBurst[0];
    end else begin
      s1_arvalid = valid; s1_araddr = reqAddr[1]; s1_arlen = reqLen[1];
      s1_arsize = reqSize[1]; s1_arburst = reqBurst[1];
    end
  endtask

  // Enter with the DUT idle and requests driven; returns one cycle after the closing beat.
  task automatic runBurst(input int delta, input bit badRid, input int stallMode,
                          input bit keepWinner, input bit raiseOther);
    int win, nBeats, beat, guard, stalled, waitCyc;
    bit rv, rr;
    logic [IW-1:0] winId;
    if (s0_arvalid && s1_arvalid) win = 1 - lastWin;
    else win = s1_arvalid ? 1 : 0;
    lastWin = win;
    winId = (win == 1) ? IW'(1) : IW'(0);
    @(posedge cpu_clk); #1;
    checkOutput("m_arvalid_latency", m_arvalid, 1);
    checkOutput("m_arid", m_arid, winId);
    checkOutput("m_araddr", m_araddr, reqAddr[win]);
    checkOutput("m_arlen", m_arlen, reqLen[win]);
    checkOutput("m_arsize", m_arsize, reqSize[win]);
    checkOutput("m_arburst", m_arburst, reqBurst[win]);
    if (raiseOther) applyStimulus(1 - win, 1, $urandom_range(0, 3));
    waitCyc = $urandom_range(0, 2);
    repeat (waitCyc) begin
      m_arready = 1'b0; #1;
      checkOutput("arready_wait", (win == 1) ? s1_arready : s0_arready, 0);
      @(posedge cpu_clk); #1;
    end
    m_arready = 1'b1; #1;
    checkOutput("arready_granted", (win == 1) ? s1_arready : s0_arready, 1);
    checkOutput("arready_other", (win == 1) ? s0_arready : s1_arready, 0);
    @(posedge cpu_clk); #1;
    m_arready = 1'b0;
    if (!keepWinner) applyStimulus(win, 0, 0);
    #1;
    checkOutput("m_arvalid_in_data", m_arvalid, 0);

    nBeats = int'(reqLen[win]) + 1 + delta;
    if (nBeats < 1) nBeats = 1;
    beat = 0; guard = 0; stalled = 0;
    while (beat < nBeats && guard < 200) begin
      guard++;
      rv = 1'b1; rr = 1'b1;
      if (stallMode == 1) begin
        rv = ($urandom_range(0, 3) != 0);
        rr = ($urandom_range(0, 3) != 0);
      end else if (stallMode == 2 && beat == 1 && stalled < 3) begin
        rr = 1'b0;
        stalled++;
      end
      m_rvalid = rv;
      m_rdata  = $urandom;
      m_rresp  = 2'($urandom_range(0, 3));
      m_rlast  = (beat == nBeats - 1);
      m_rid    = (badRid && beat == 0) ? ((win == 1) ? IW'(0) : IW'(1)) : winId;
      if (win == 1) begin s1_rready = rr; s0_rready = 1'($urandom_range(0, 1)); end
      else begin s0_rready = rr; s1_rready = 1'($urandom_range(0, 1)); end
      #1;
      checkOutput("rvalid_granted", (win == 1) ? s1_rvalid : s0_rvalid, rv);
      checkOutput("rvalid_other", (win == 1) ? s0_rvalid : s1_rvalid, 0);
      checkOutput("rdata_granted", (win == 1) ? s1_rdata : s0_rdata, m_rdata);
      checkOutput("rdata_other", (win == 1) ? s0_rdata : s1_rdata, 0);
      checkOutput("rresp_granted", (win == 1) ? s1_rresp : s0_rresp, m_rresp);
      checkOutput("rlast_granted", (win == 1) ? s1_rlast : s0_rlast, m_rlast);
      checkOutput("m_rready", m_rready, rr);
      checkOutput("arready_other_data", (win == 1) ? s0_arready : s1_arready, 0);
      @(posedge cpu_clk);
      if (rv && rr) beat++;
      #1;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
    #1;
    checkOutput("burst_completed", beat == nBeats, 1);
    checkOutput("m_arvalid_after_rlast", m_arvalid, 0);
    checkOutput("m_rready_after_rlast", m_rready, 0);
    if (nBeats != int'(reqLen[win]) + 1) expErrLen = 1'b1;
    if (badRid) expErrId = 1'b1;
    checkOutput("err_len", err_len, expErrLen);
    checkOutput("err_id", err_id, expErrId);
  endtask

  initial begin
    repeat (2) @(posedge cpu_clk);
    #1;
    checkOutput("reset_m_arvalid", m_arvalid, 0);
    checkOutput("reset_m_rready", m_rready, 0);
    checkOutput("reset_arready", {s0_arready, s1_arready}, 0);
    checkOutput("reset_m_araddr", m_araddr, 0);
    checkOutput("reset_errs", {err_id, err_len}, 0);
    cpu_reset_n = 1'b1;
    @(posedge cpu_clk); #1;
    checkOutput("idle_m_arvalid", m_arvalid, 0);

    $display("[TB] round-robin with both requesters held");
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 4; i++) runBurst(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);

    $display("[TB] single s0 burst of 4 beats at 0x1000");
    applyStimulus(0, 1, 3);
    reqAddr[0] = 32'h1000;
    s0_araddr = 32'h1000;
    runBurst(0, 0, 0, 0, 0);

    $display("[TB] s1 burst with s0 waiting, then s0 at K+2");
    applyStimulus(1, 1, 3);
    runBurst(0, 0, 0, 0, 1);
    runBurst(0, 0, 0, 0, 0);

    $display("[TB] early rlast and sticky length error");
    applyStimulus(0, 1, 2);
    runBurst(-1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1);
    runBurst(0, 0, 1, 0, 0);

    $display("[TB] wrong RID and rready stall");
    applyStimulus(0, 1, 3);
    runBurst(0, 1, 2, 0, 0);

    $display("[TB] arvalid withdrawn before address handshake");
    applyStimulus(1, 1, 2);
    lastWin = 1;
    @(posedge cpu_clk); #1;
    checkOutput("withdraw_m_arvalid", m_arvalid, 1);
    checkOutput("withdraw_m_arid", m_arid, IW'(1));
    applyStimulus(1, 0, 0);
    #1;
    checkOutput("withdraw_drop", m_arvalid, 0);
    @(posedge cpu_clk); #1;
    applyStimulus(0, 1, 1);
    applyStimulus(1, 1, 1);
    runBurst(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0);

    $display("[TB] reset in the middle of a burst");
    applyStimulus(0, 1, 3);
    @(posedge cpu_clk); #1;
    m_arready = 1'b1;
    @(posedge cpu_clk); #1;
    m_arready = 1'b0;
    applyStimulus(0, 0, 0);
    m_rvalid = 1'b1; m_rdata = $urandom; m_rid = '0; m_rlast = 1'b0; s0_rready = 1'b1;
    @(posedge cpu_clk); #1;
    cpu_reset_n = 1'b0;
    m_rlast = 1'b1;
    @(posedge cpu_clk); #1;
    cpu_reset_n = 1'b1;
    checkOutput("midreset_s0_rvalid", s0_rvalid, 0);
    checkOutput("midreset_s0_rdata", s0_rdata, 0);
    checkOutput("midreset_s0_rlast", s0_rlast, 0);
    checkOutput("midreset_m_rready", m_rready, 0);
    checkOutput("midreset_m_arvalid", m_arvalid, 0);
    checkOutput("midreset_errs", {err_id, err_len}, 0);
    m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b0;
    expErrId = 1'b0; expErrLen = 1'b0; lastWin = 1;
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    runBurst(0, 0, 0, 0, 0);

    $display("[TB] randomized bursts");
    for (int it = 0; it < 12; it++) begin
      bit want0, want1;
      int d;
      want0 = 1'($urandom_range(0, 1));
      want1 = 1'($urandom_range(0, 1));
      if (!want0 && !want1 && !s0_arvalid && !s1_arvalid) want0 = 1'b1;
      if (want0 && !s0_arvalid) applyStimulus(0, 1, $urandom_range(0, 4));
      if (want1 && !s1_arvalid) applyStimulus(1, 1, $urandom_range(0, 4));
      case ($urandom_range(0, 5))
        0: d = 1;
        1: d = -1;
        default: d = 0;
      endcase
      runBurst(d, $urandom_range(0, 7) == 0, 1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
